// File: rtl/idss_loader_if.sv
// Stream, IDSS-drive and window-handshake signals of the IDSS loader.
interface idss_loader_if #(
  parameter int unsigned IO_DATA_WIDTH     = 16,
  parameter int unsigned FEATURE_MAP_WIDTH = 1024,
  parameter int unsigned NB_GROUPS         = 4
);
  logic                                 start;
  logic [IO_DATA_WIDTH-1:0]             in_row_1;
  logic [IO_DATA_WIDTH-1:0]             in_row_2;
  logic [IO_DATA_WIDTH-1:0]             in_row_3;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [IO_DATA_WIDTH-1:0]             row_1;
  logic [IO_DATA_WIDTH-1:0]             row_2;
  logic [IO_DATA_WIDTH-1:0]             row_3;
  logic                                 shift;
  logic [$clog2(NB_GROUPS)-1:0]         LE_select;
  logic                                 window_valid;
  logic                                 window_ack;
  logic [$clog2(FEATURE_MAP_WIDTH)-1:0] col_idx;
  logic                                 band_done;
  logic                                 busy;

  modport master (
    output start, in_row_1, in_row_2, in_row_3, in_valid, window_ack,
    input  in_ready, row_1, row_2, row_3, shift, LE_select,
           window_valid, col_idx, band_done, busy
  );

  modport slave (
    input  start, in_row_1, in_row_2, in_row_3, in_valid, window_ack,
    output in_ready, row_1, row_2, row_3, shift, LE_select,
           window_valid, col_idx, band_done, busy
  );
endinterface

// File: rtl/idss_loader.sv
// Sequences a column/group beat stream into the IDSS and announces each
// complete KERNEL_SIZE x KERNEL_SIZE x NB_GROUPS window to the MAC controller.
module idss_loader #(
  parameter int unsigned IO_DATA_WIDTH     = 16,
  parameter int unsigned FEATURE_MAP_WIDTH = 1024,
  parameter int unsigned KERNEL_SIZE       = 3,
  parameter int unsigned NB_GROUPS         = 4
) (
  input  logic          clk,
  input  logic          arst_in,
  idss_loader_if.slave  bus
);
  localparam int unsigned GW   = $clog2(NB_GROUPS);
  localparam int unsigned CW   = $clog2(FEATURE_MAP_WIDTH);
  localparam int unsigned BW   = $clog2(KERNEL_SIZE * NB_GROUPS);
  localparam int unsigned NWIN = FEATURE_MAP_WIDTH - KERNEL_SIZE + 1;

  localparam logic [BW-1:0] FILL_LAST  = BW'(KERNEL_SIZE * NB_GROUPS - 1);
  localparam logic [BW-1:0] SLIDE_LAST = BW'(NB_GROUPS - 1);
  localparam logic [GW-1:0] GRP_LAST   = GW'(NB_GROUPS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(NWIN - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT,
    SLIDE
  } state_e;

  state_e                   state_q, state_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [GW-1:0]            grp_q, grp_d;
  logic [CW-1:0]            col_q, col_d;
  logic [IO_DATA_WIDTH-1:0] row1_q, row1_d;
  logic [IO_DATA_WIDTH-1:0] row2_q, row2_d;
  logic [IO_DATA_WIDTH-1:0] row3_q, row3_d;
  logic [GW-1:0]            le_q, le_d;
  logic                     shift_q, shift_d;
  logic                     wv_q, wv_d;
  logic                     bd_q, bd_d;

  logic in_ready;
  logic accept;
  logic ack;

  assign in_ready = (state_q == FILL) || (state_q == SLIDE);
  assign accept   = bus.in_valid && in_ready;
  assign ack      = (state_q == WAIT) && wv_q && bus.window_ack;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    grp_d   = grp_q;
    col_d   = col_q;
    row1_d  = row1_q;
    row2_d  = row2_q;
    row3_d  = row3_q;
    le_d    = le_q;
    shift_d = accept;
    wv_d    = wv_q;
    bd_d    = 1'b0;

    if (accept) begin
      row1_d = bus.in_row_1;
      row2_d = bus.in_row_2;
      row3_d = bus.in_row_3;
      le_d   = grp_q;
      grp_d  = (grp_q == GRP_LAST) ? '0 : grp_q + GW'(1);
      beat_d = beat_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        // a start coinciding with the band_done pulse is dropped
        if (bus.start && !bd_q) begin
          state_d = FILL;
          beat_d  = '0;
          grp_d   = '0;
          col_d   = '0;
        end
      end
      FILL: begin
        if (accept && (beat_q == FILL_LAST)) begin
          state_d = WAIT;
          beat_d  = '0;
        end
      end
      WAIT: begin
        // first WAIT cycle carries the window's last shift; announce after it
        if (shift_q) begin
          wv_d = 1'b1;
        end
        if (ack) begin
          wv_d = 1'b0;
          if (col_q == COL_LAST) begin
            state_d = IDLE;
            bd_d    = 1'b1;
          end else begin
            state_d = SLIDE;
            col_d   = col_q + CW'(1);
          end
        end
      end
      SLIDE: begin
        if (accept && (beat_q == SLIDE_LAST)) begin
          state_d = WAIT;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q <= IDLE;
      beat_q  <= '0;
      grp_q   <= '0;
      col_q   <= '0;
      row1_q  <= '0;
      row2_q  <= '0;
      row3_q  <= '0;
      le_q    <= '0;
      shift_q <= 1'b0;
      wv_q    <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grp_q   <= grp_d;
      col_q   <= col_d;
      row1_q  <= row1_d;
      row2_q  <= row2_d;
      row3_q  <= row3_d;
      le_q    <= le_d;
      shift_q <= shift_d;
      wv_q    <= wv_d;
      bd_q    <= bd_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.row_1        = row1_q;
  assign bus.row_2        = row2_q;
  assign bus.row_3        = row3_q;
  assign bus.shift        = shift_q;
  assign bus.LE_select    = le_q;
  assign bus.window_valid = wv_q;
  assign bus.col_idx      = col_q;
  assign bus.band_done    = bd_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
